// File: rtl/lock_pkg.sv
// ============================================================================
//  Package     : lock_pkg
//  Description : Shared button indices, vector type and debounce default for
//                the combination-lock front end and FSM.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package lock_pkg;

    localparam int BTN_A   = 0;
    localparam int BTN_B   = 1;
    localparam int BTN_C   = 2;
    localparam int NUM_BTN = 3;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    typedef logic [NUM_BTN-1:0] btn_vec_t;

    function automatic logic [1:0] btn_popcount(input btn_vec_t v);
        logic [1:0] n;
        n = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            n = n + {1'b0, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_chan.sv
// ============================================================================
//  Module      : debounce_chan
//  Description : One button channel: 2-FF synchronizer, counter debouncer and
//                rising-edge one-shot on the committed level.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module debounce_chan
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic RAW,
    output logic LVL,
    output logic PULSE,
    output logic PULSE_NXT
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             lvl_q, lvl_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d    = RAW;
        s2_d    = s1_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (s2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // Commit; only a 0->1 commit produces the press pulse.
            lvl_d   = s2_q;
            cnt_d   = '0;
            pulse_d = s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            lvl_q   <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign LVL       = lvl_q;
    assign PULSE     = pulse_q;
    assign PULSE_NXT = pulse_d;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
//  Module      : button_conditioner
//  Description : Conditions the three raw lock buttons into debounced levels,
//                single-cycle press pulses and a coincident-press flag.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module button_conditioner
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic A_RAW,
    input  logic B_RAW,
    input  logic C_RAW,
    output logic A,
    output logic B,
    output logic C,
    output logic A_LVL,
    output logic B_LVL,
    output logic C_LVL,
    output logic MULTI
);

    btn_vec_t raw_vec;
    btn_vec_t lvl_vec;
    btn_vec_t pulse_vec;
    btn_vec_t pulse_nxt_vec;

    logic multi_q, multi_d;

    assign raw_vec[BTN_A] = A_RAW;
    assign raw_vec[BTN_B] = B_RAW;
    assign raw_vec[BTN_C] = C_RAW;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .CLK      (CLK),
            .RST      (RST),
            .RAW      (raw_vec[i]),
            .LVL      (lvl_vec[i]),
            .PULSE    (pulse_vec[i]),
            .PULSE_NXT(pulse_nxt_vec[i])
        );
    end

    // Built from next-state pulses so MULTI lines up with the pulses it flags.
    always_comb begin
        multi_d = (btn_popcount(pulse_nxt_vec) >= 2'd2);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            multi_q <= 1'b0;
        end else begin
            multi_q <= multi_d;
        end
    end

    assign A     = pulse_vec[BTN_A];
    assign B     = pulse_vec[BTN_B];
    assign C     = pulse_vec[BTN_C];
    assign A_LVL = lvl_vec[BTN_A];
    assign B_LVL = lvl_vec[BTN_B];
    assign C_LVL = lvl_vec[BTN_C];
    assign MULTI = multi_q;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed self-checking bench for button_conditioner.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_button_conditioner;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic A_RAW = 1'b0, B_RAW = 1'b0, C_RAW = 1'b0;
    logic A, B, C, A_LVL, B_LVL, C_LVL, MULTI;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-window observations, indexed 0=A 1=B 2=C; edge numbers are 1-based
    // counting from the first edge after the stimulus was applied.
    int pulse_cnt  [3];
    int pulse_first[3];
    int lvl_hi_cnt [3];
    int lvl_lo_first[3];
    int multi_cnt;
    int multi_first;

    button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .A_RAW(A_RAW),
        .B_RAW(B_RAW),
        .C_RAW(C_RAW),
        .A    (A),
        .B    (B),
        .C    (C),
        .A_LVL(A_LVL),
        .B_LVL(B_LVL),
        .C_LVL(C_LVL),
        .MULTI(MULTI)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n edges, sampling 1 ns after each edge.
    task automatic run(input int n);
        logic [2:0] p, l;
        for (int c = 0; c < 3; c++) begin
            pulse_cnt[c]    = 0;
            pulse_first[c]  = -1;
            lvl_hi_cnt[c]   = 0;
            lvl_lo_first[c] = -1;
        end
        multi_cnt   = 0;
        multi_first = -1;
        for (int e = 1; e <= n; e++) begin
            @(posedge CLK);
            #1;
            p = {C, B, A};
            l = {C_LVL, B_LVL, A_LVL};
            for (int c = 0; c < 3; c++) begin
                if (p[c]) begin
                    pulse_cnt[c]++;
                    if (pulse_first[c] < 0) pulse_first[c] = e;
                end
                if (l[c]) lvl_hi_cnt[c]++;
                else if (lvl_lo_first[c] < 0) lvl_lo_first[c] = e;
            end
            if (MULTI) begin
                multi_cnt++;
                if (multi_first < 0) multi_first = e;
            end
        end
    endtask

    initial begin
        // 1. Reset with all raw lines high
        A_RAW = 1'b1; B_RAW = 1'b1; C_RAW = 1'b1;
        RST   = 1'b0;
        run(8);
        check("reset_outputs", int'({A, B, C, A_LVL, B_LVL, C_LVL, MULTI}), 0);
        A_RAW = 1'b0; C_RAW = 1'b0;
        RST   = 1'b1;
        run(12);
        check("rst_rel_b_count", pulse_cnt[1], 1);
        check("rst_rel_b_edge",  pulse_first[1], 6);
        check("rst_rel_b_lvl",   int'(B_LVL), 1);
        check("rst_rel_a_count", pulse_cnt[0], 0);
        check("rst_rel_c_count", pulse_cnt[2], 0);

        // Held button does not pulse again; release commits without pulsing
        B_RAW = 1'b0;
        run(10);
        check("b_release_pulse", pulse_cnt[1], 0);
        check("b_release_edge",  lvl_lo_first[1], 6);

        // 2. Clean press of C held 20 cycles
        C_RAW = 1'b1;
        run(20);
        check("c_press_count", pulse_cnt[2], 1);
        check("c_press_edge",  pulse_first[2], 6);
        check("c_press_lvl_cycles", lvl_hi_cnt[2], 15);
        check("c_press_multi", multi_cnt, 0);

        // 3. Bounce on A then hold
        A_RAW = 1'b1; run(1);
        check("a_bounce_p1", pulse_cnt[0], 0);
        A_RAW = 1'b0; run(1);
        check("a_bounce_p2", pulse_cnt[0], 0);
        A_RAW = 1'b1; run(1);
        check("a_bounce_p3", pulse_cnt[0], 0);
        A_RAW = 1'b0; run(1);
        check("a_bounce_p4", pulse_cnt[0], 0);
        A_RAW = 1'b1;
        run(12);
        check("a_settle_count", pulse_cnt[0], 1);
        check("a_settle_edge",  pulse_first[0], 6);

        // 4. Glitch on B of 3 cycles is rejected
        B_RAW = 1'b1; run(3);
        check("b_glitch_pulse_hi", pulse_cnt[1], 0);
        check("b_glitch_lvl_hi",   lvl_hi_cnt[1], 0);
        B_RAW = 1'b0; run(10);
        check("b_glitch_pulse_lo", pulse_cnt[1], 0);
        check("b_glitch_lvl_lo",   lvl_hi_cnt[1], 0);

        // Exactly DEBOUNCE_CYCLES high is enough to commit
        B_RAW = 1'b1; run(4);
        B_RAW = 1'b0; run(12);
        check("b_exact_count", pulse_cnt[1], 1);
        check("b_exact_edge",  pulse_first[1], 2);
        check("b_exact_lvl_end", int'(B_LVL), 0);

        // 5. Simultaneous A and C
        A_RAW = 1'b0; C_RAW = 1'b0;
        run(10);
        check("ac_released_lvls", int'({A_LVL, C_LVL}), 0);
        A_RAW = 1'b1; C_RAW = 1'b1;
        run(10);
        check("sim_a_edge",  pulse_first[0], 6);
        check("sim_c_edge",  pulse_first[2], 6);
        check("sim_multi_edge",  multi_first, 6);
        check("sim_multi_count", multi_cnt, 1);
        check("sim_b_count", pulse_cnt[1], 0);

        // 6. Release and re-press C twice
        C_RAW = 1'b0; run(10);
        check("c_rel1_pulse", pulse_cnt[2], 0);
        check("c_rel1_edge",  lvl_lo_first[2], 6);
        C_RAW = 1'b1; run(10);
        check("c_press2_count", pulse_cnt[2], 1);
        C_RAW = 1'b0; run(10);
        check("c_rel2_edge",  lvl_lo_first[2], 6);
        C_RAW = 1'b1; run(10);
        check("c_press3_count", pulse_cnt[2], 1);
        check("c_press3_edge",  pulse_first[2], 6);

        // Reset two cycles into a press of B discards it
        B_RAW = 1'b1; run(2);
        #2;
        RST = 1'b0;
        #1;
        check("async_reset_lvls", int'({A_LVL, C_LVL}), 0);
        B_RAW = 1'b0;
        run(2);
        RST = 1'b1;
        run(10);
        check("rst_mid_b_count", pulse_cnt[1], 0);
        check("rst_mid_b_lvl",   lvl_hi_cnt[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
